// File: rtl/tile_load_pkg.sv
// Shared types and constants for the tile load sequencer.
// The state encodings are fixed 3-bit constants so they stay stable for
// anything that decodes the state value directly.
package tile_load_pkg;

    // Address bit that separates kernel words (1) from input words (0).
    localparam int KERNEL_SEL_BIT = 15;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_LOAD_KERNEL  = 3'd1;
    localparam logic [2:0] ST_LOAD_INPUT   = 3'd2;
    localparam logic [2:0] ST_LOAD_OVERLAP = 3'd3;
    localparam logic [2:0] ST_COMPUTE      = 3'd4;
    localparam logic [2:0] ST_DONE         = 3'd5;

    typedef enum logic [2:0] {
        TL_IDLE         = ST_IDLE,
        TL_LOAD_KERNEL  = ST_LOAD_KERNEL,
        TL_LOAD_INPUT   = ST_LOAD_INPUT,
        TL_LOAD_OVERLAP = ST_LOAD_OVERLAP,
        TL_COMPUTE      = ST_COMPUTE,
        TL_DONE         = ST_DONE
    } tl_state_t;

    // Largest of three phase lengths; sizes the shared word counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tile_load_sequencer_tl_word_counter.sv
// Per-phase word counter. Counts accepted words and flags the word that
// completes the phase, so the phase ends on terminal count and the counter
// restarts from zero for the next phase without ever wrapping.
module tl_word_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] phase_len,
    output logic             terminal
);

    logic [CNT_W-1:0] count_reg;

    // The word being accepted now is the last one of the phase.
    assign terminal = inc && ((count_reg + CNT_W'(1)) == phase_len);

    // Count accepted words; restart on an explicit clear or at phase end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear || terminal) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tile_load_sequencer.sv
// Loads one convolution layer into on-chip memories: kernel once, then per
// tile the input words and the overlap-cache words, handing each loaded tile
// to the controller and waiting for its done pulse before the next tile.
module tile_load_sequencer
    import tile_load_pkg::*;
#(
    parameter int IO_DATA_WIDTH = 16,
    parameter int KERNEL_WORDS  = 512,
    parameter int INPUT_WORDS   = 16384,
    parameter int OVERLAP_WORDS = 256,
    parameter int NB_TILES      = 4
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     start,
    input  logic [IO_DATA_WIDTH-1:0] a_input,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [IO_DATA_WIDTH-1:0] b_input,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic                     fsm_done,
    output logic [IO_DATA_WIDTH-1:0] wr_addr,
    output logic [IO_DATA_WIDTH-1:0] wr_data,
    output logic                     int_mem_we,
    output logic                     overlap_cache_we,
    output logic                     data_ready,
    output logic [((NB_TILES > 1) ? $clog2(NB_TILES) : 1)-1:0] tile_idx,
    output logic                     layer_done,
    output logic                     load_error
);

    localparam int TILE_W = (NB_TILES > 1) ? $clog2(NB_TILES) : 1;
    localparam int CNT_W  = $clog2(max3(KERNEL_WORDS, INPUT_WORDS, OVERLAP_WORDS) + 1);

    tl_state_t            state_reg, state_next;
    logic [TILE_W-1:0]    tile_reg, tile_next;
    logic [IO_DATA_WIDTH-1:0] wr_addr_reg, wr_data_reg;
    logic                 int_we_reg, ov_we_reg, load_error_reg;

    logic                 ready;
    logic                 accept;
    logic                 start_go;
    logic                 phase_ok;
    logic [CNT_W-1:0]     phase_len;
    logic                 terminal;

    // Ready depends only on the registered state, never on valid.
    assign ready    = (state_reg == TL_LOAD_KERNEL) ||
                      (state_reg == TL_LOAD_INPUT)  ||
                      (state_reg == TL_LOAD_OVERLAP);
    assign accept   = a_valid && b_valid && ready;
    assign start_go = (state_reg == TL_IDLE) && start;

    assign a_ready          = ready;
    assign b_ready          = ready;
    assign wr_addr          = wr_addr_reg;
    assign wr_data          = wr_data_reg;
    assign int_mem_we       = int_we_reg;
    assign overlap_cache_we = ov_we_reg;
    assign data_ready       = (state_reg == TL_COMPUTE);
    assign layer_done       = (state_reg == TL_DONE);
    assign tile_idx         = tile_reg;
    assign load_error       = load_error_reg;

    tl_word_counter #(
        .CNT_W (CNT_W)
    ) u_word_counter (
        .clk       (clk),
        .rst_n     (arst_n_in),
        .clear     (start_go),
        .inc       (accept),
        .phase_len (phase_len),
        .terminal  (terminal)
    );

    // Phase length and bit-15 acceptance rule for the current load phase.
    always_comb begin
        phase_len = '0;
        phase_ok  = 1'b1;
        case (state_reg)
            TL_LOAD_KERNEL: begin
                phase_len = CNT_W'(KERNEL_WORDS);
                phase_ok  = a_input[KERNEL_SEL_BIT];
            end
            TL_LOAD_INPUT: begin
                phase_len = CNT_W'(INPUT_WORDS);
                phase_ok  = !a_input[KERNEL_SEL_BIT];
            end
            TL_LOAD_OVERLAP: begin
                phase_len = CNT_W'(OVERLAP_WORDS);
            end
            default: begin
                phase_len = '0;
                phase_ok  = 1'b1;
            end
        endcase
    end

    // Next state and tile index.
    always_comb begin
        state_next = state_reg;
        tile_next  = tile_reg;
        case (state_reg)
            TL_IDLE: begin
                if (start) begin
                    state_next = TL_LOAD_KERNEL;
                    tile_next  = '0;
                end
            end
            TL_LOAD_KERNEL: begin
                if (terminal) state_next = TL_LOAD_INPUT;
            end
            TL_LOAD_INPUT: begin
                if (terminal) state_next = (OVERLAP_WORDS == 0) ? TL_COMPUTE : TL_LOAD_OVERLAP;
            end
            TL_LOAD_OVERLAP: begin
                if (terminal) state_next = TL_COMPUTE;
            end
            TL_COMPUTE: begin
                if (fsm_done) begin
                    if (tile_reg == TILE_W'(NB_TILES - 1)) begin
                        state_next = TL_DONE;
                    end else begin
                        tile_next  = tile_reg + TILE_W'(1);
                        state_next = TL_LOAD_INPUT;
                    end
                end
            end
            TL_DONE: begin
                state_next = TL_IDLE;
            end
            default: begin
                state_next = TL_IDLE;
            end
        endcase
    end

    // State, write pipeline and sticky error flag; reset cancels any strobe.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_reg      <= TL_IDLE;
            tile_reg       <= '0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            int_we_reg     <= 1'b0;
            ov_we_reg      <= 1'b0;
            load_error_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tile_reg   <= tile_next;
            int_we_reg <= accept && phase_ok && (state_reg != TL_LOAD_OVERLAP);
            ov_we_reg  <= accept && (state_reg == TL_LOAD_OVERLAP);
            if (accept) begin
                wr_addr_reg <= a_input;
                wr_data_reg <= b_input;
            end
            if (start_go) begin
                load_error_reg <= 1'b0;
            end else if (accept && !phase_ok) begin
                load_error_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tile_load_sequencer.sv
// Bench for tile_load_sequencer: table-driven word streams with a strobe
// scoreboard, plus hand sequences for compute handoff, reset and the
// no-overlap configuration (second instance).
module tb_tile_load_sequencer;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          kind;   // 0 dropped, 1 int_mem_we, 2 overlap_cache_we
        bit          err;    // load_error expected the cycle after acceptance
        int          gap;    // idle cycles with valid low before the word
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n, start0, start1, a_valid, b_valid, fsm_done;
    logic [15:0] a_input, b_input;

    logic        a_ready, b_ready, int_mem_we, overlap_cache_we, data_ready, layer_done, load_error;
    logic [15:0] wr_addr, wr_data;
    logic [0:0]  tile_idx;

    logic        a_ready1, b_ready1, int_mem_we1, overlap_cache_we1, data_ready1, layer_done1, load_error1;
    logic [15:0] wr_addr1, wr_data1;
    logic [0:0]  tile_idx1;

    tile_load_sequencer #(
        .IO_DATA_WIDTH(16), .KERNEL_WORDS(4), .INPUT_WORDS(8), .OVERLAP_WORDS(2), .NB_TILES(2)
    ) dut (
        .clk(clk), .arst_n_in(arst_n), .start(start0),
        .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready),
        .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready),
        .fsm_done(fsm_done), .wr_addr(wr_addr), .wr_data(wr_data),
        .int_mem_we(int_mem_we), .overlap_cache_we(overlap_cache_we),
        .data_ready(data_ready), .tile_idx(tile_idx),
        .layer_done(layer_done), .load_error(load_error)
    );

    tile_load_sequencer #(
        .IO_DATA_WIDTH(16), .KERNEL_WORDS(4), .INPUT_WORDS(8), .OVERLAP_WORDS(0), .NB_TILES(1)
    ) dut_noov (
        .clk(clk), .arst_n_in(arst_n), .start(start1),
        .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready1),
        .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready1),
        .fsm_done(fsm_done), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .int_mem_we(int_mem_we1), .overlap_cache_we(overlap_cache_we1),
        .data_ready(data_ready1), .tile_idx(tile_idx1),
        .layer_done(layer_done1), .load_error(load_error1)
    );

    int   total = 0;
    int   bad   = 0;
    vec_t exp_q[$];
    int   int_cnt = 0, ov_cnt = 0, done_cnt = 0;
    int   int1_cnt = 0, ov1_cnt = 0, done1_cnt = 0;
    vec_t tbl1[24];
    vec_t tbl2[24];

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] d,
                                input int k, input bit e, input int g);
        vec_t v;
        v.addr = a; v.data = d; v.kind = k; v.err = e; v.gap = g;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: compare the strobes present in the current cycle.
    task automatic sb_check();
        vec_t e;
        if (int_mem_we || overlap_cache_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got we=%b ov=%b addr=%h expected no strobe",
                         int_mem_we, overlap_cache_we, wr_addr);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", {30'd0, int_mem_we, overlap_cache_we}, (e.kind == 1) ? 32'd2 : 32'd1);
                check("wr_addr", {16'd0, wr_addr}, {16'd0, e.addr});
                check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
                $display("xfer kind=%0d addr=%h data=%h", e.kind, wr_addr, wr_data);
            end
        end
        if (int_mem_we)        int_cnt++;
        if (overlap_cache_we)  ov_cnt++;
        if (layer_done)        done_cnt++;
        if (int_mem_we1)       int1_cnt++;
        if (overlap_cache_we1) ov1_cnt++;
        if (layer_done1)       done1_cnt++;
    endtask

    // Advance one cycle, scoreboarding this cycle's outputs on the way.
    task automatic step();
        @(negedge clk);
        sb_check();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        step();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic pulse_done();
        fsm_done = 1'b1;
        step();
        fsm_done = 1'b0;
    endtask

    // Drive one word until accepted; returns in the cycle after acceptance.
    task automatic send_word(input vec_t w, input bit sel);
        int waited;
        waited = 0;
        if (w.gap > 0) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
            repeat (w.gap) begin
                check("ready_in_gap", sel ? a_ready1 : a_ready, 1);
                step();
            end
        end
        a_input = w.addr;
        b_input = w.data;
        a_valid = 1'b1;
        b_valid = 1'b1;
        while (!(sel ? (a_ready1 && b_ready1) : (a_ready && b_ready))) begin
            if (waited == 20) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: got ready=0 for %0d cycles expected ready=1 addr=%h", waited, w.addr);
                a_valid = 1'b0;
                b_valid = 1'b0;
                return;
            end
            step();
            waited++;
        end
        if (!sel && w.kind != 0) exp_q.push_back(w);
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (!sel) check("load_error", load_error, w.err);
    endtask

    task automatic run_range(input int which, input int lo, input int hi, input bit sel);
        for (int i = lo; i <= hi; i++) begin
            if (which == 1) send_word(tbl1[i], sel);
            else            send_word(tbl2[i], sel);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_ready"}, a_ready, 0);
        check({tag, "_b_ready"}, b_ready, 0);
        check({tag, "_int_we"}, int_mem_we, 0);
        check({tag, "_ov_we"}, overlap_cache_we, 0);
        check({tag, "_data_ready"}, data_ready, 0);
        check({tag, "_layer_done"}, layer_done, 0);
        check({tag, "_load_error"}, load_error, 0);
        check({tag, "_wr_addr"}, {16'd0, wr_addr}, 0);
        check({tag, "_wr_data"}, {16'd0, wr_data}, 0);
        check({tag, "_tile_idx"}, tile_idx, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_int, b_ov, b_done;

        // Stimulus tables for a full two-tile layer.
        for (int i = 0; i < 4; i++) tbl1[i]      = mk(16'h8000 | 16'(i), 16'hA000 + 16'(i), 1, 0, 0);
        for (int i = 0; i < 8; i++) tbl1[4 + i]  = mk(16'(i * 3), 16'hB000 + 16'(i), 1, 0, 0);
        for (int i = 0; i < 2; i++) tbl1[12 + i] = mk(16'h7F00 + 16'(i), 16'hC000 + 16'(i), 2, 0, 0);
        for (int i = 0; i < 8; i++) tbl1[14 + i] = mk(16'h0100 + 16'(i), 16'hD000 + 16'(i), 1, 0, 1);
        for (int i = 0; i < 2; i++) tbl1[22 + i] = mk(16'hFF00 + 16'(i), 16'hE000 + 16'(i), 2, 0, 1);
        for (int i = 0; i < 24; i++) begin
            tbl2[i]      = tbl1[i];
            tbl2[i].data = tbl1[i].data ^ 16'h0F0F;
            tbl2[i].err  = (i >= 1);
            tbl2[i].gap  = 0;
        end
        tbl2[1].addr = 16'h0003;
        tbl2[1].kind = 0;

        arst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; fsm_done = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_input = '0; b_input = '0;
        repeat (3) step();
        check_all_zero("reset");
        arst_n = 1'b1;
        step();
        check("idle_ready", a_ready, 0);

        // Layer 1: full stream, tile 0 back-to-back, tile 1 with valid toggling.
        b_int = int_cnt; b_ov = ov_cnt; b_done = done_cnt;
        pulse_start(0);
        check("start_a_ready", a_ready, 1);
        check("start_b_ready", b_ready, 1);
        run_range(1, 0, 13, 0);
        check("t0_data_ready", data_ready, 1);
        check("t0_last_ov_we", overlap_cache_we, 1);
        check("t0_ready_low", a_ready, 0);
        idle(1);
        check("t0_int_count", int_cnt - b_int, 12);
        check("t0_ov_count", ov_cnt - b_ov, 2);
        pulse_start(0);
        check("start_in_compute_dr", data_ready, 1);
        check("start_in_compute_tile", tile_idx, 0);
        pulse_done();
        check("done0_data_ready", data_ready, 0);
        check("done0_tile_idx", tile_idx, 1);
        check("done0_ready", a_ready, 1);
        run_range(1, 14, 16, 0);
        pulse_done();
        check("spurious_done_ready", a_ready, 1);
        check("spurious_done_tile", tile_idx, 1);
        check("spurious_done_dr", data_ready, 0);
        run_range(1, 17, 23, 0);
        check("t1_data_ready", data_ready, 1);
        idle(1);
        check("t1_int_count", int_cnt - b_int, 20);
        check("t1_ov_count", ov_cnt - b_ov, 4);
        check("t1_queue_empty", exp_q.size(), 0);
        pulse_done();
        check("layer_done_pulse", layer_done, 1);
        check("last_done_dr", data_ready, 0);
        check("last_tile_idx", tile_idx, 1);
        idle(1);
        check("layer_done_low", layer_done, 0);
        check("idle_ready_after", a_ready, 0);
        idle(2);
        check("layer_done_count", done_cnt - b_done, 1);

        // Layer 2: mis-phased kernel word is counted, dropped and flagged.
        pulse_start(0);
        check("l2_err_clear", load_error, 0);
        run_range(2, 0, 13, 0);
        check("l2_data_ready", data_ready, 1);
        pulse_start(0);
        check("l2_err_sticky_start", load_error, 1);
        check("l2_start_ignored", data_ready, 1);
        pulse_done();
        run_range(2, 14, 23, 0);
        pulse_done();
        idle(2);
        check("l2_err_in_idle", load_error, 1);
        check("l2_queue_empty", exp_q.size(), 0);
        pulse_start(0);
        check("l3_err_cleared", load_error, 0);

        // Layer 3: reset in the middle of the input phase, strobe in flight.
        run_range(2, 0, 6, 0);
        check("pre_reset_strobe", int_mem_we, 1);
        arst_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        check_all_zero("async");
        exp_q.delete();
        step();
        check_all_zero("rst_next");
        arst_n = 1'b1;
        step();

        // Layer 4: kernel restarts from word 0.
        pulse_start(0);
        run_range(1, 0, 4, 0);
        idle(1);
        check("l4_queue_empty", exp_q.size(), 0);
        check("l4_in_input_ready", a_ready, 1);
        arst_n = 1'b0;
        idle(1);
        arst_n = 1'b1;
        idle(1);

        // No-overlap instance: input phase goes straight to compute.
        b_int = int1_cnt; b_ov = ov1_cnt;
        pulse_start(1);
        check("noov_ready", a_ready1, 1);
        run_range(1, 0, 11, 1);
        check("noov_data_ready", data_ready1, 1);
        check("noov_ready_low", a_ready1, 0);
        idle(1);
        check("noov_int_count", int1_cnt - b_int, 12);
        check("noov_ov_count", ov1_cnt - b_ov, 0);
        check("noov_main_idle", a_ready, 0);
        pulse_done();
        check("noov_layer_done", layer_done1, 1);
        check("noov_tile_idx", tile_idx1, 0);
        idle(2);
        check("noov_done_count", done1_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_load_sequencer.md
# tile_load_sequencer

Sequences the loading of one convolution layer into the chip's on-chip memories and hands each loaded tile to `controller_fsm`. It accepts (address, data) word pairs on the `a`/`b` valid/ready stream, sorts them by phase into kernel, input and overlap-cache writes, and drives `int_mem_we`, `overlap_cache_we` and `data_ready`. It then waits for the controller's `fsm_done` before loading the next tile. It sits between the chip IO stream and the `input_mem`/`kernel_mem`/`overlap_cache` write ports.

## Interface
Parameters:
- `IO_DATA_WIDTH`, 16: width of the address and data words.
- `KERNEL_WORDS`, 512: words in the kernel phase; loaded once per layer.
- `INPUT_WORDS`, 16384: words in the input phase; loaded per tile.
- `OVERLAP_WORDS`, 256: words in the overlap phase; loaded per tile. A value of 0 skips the phase.
- `NB_TILES`, 4: tiles per layer.

Ports:
- `clk` in 1: the only clock.
- `arst_n_in` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; begins a layer; honoured only in IDLE.
- `a_input` in IO_DATA_WIDTH: write address; bit 15 is the kernel/input select.
- `a_valid` in 1; `a_ready` out 1.
- `b_input` in IO_DATA_WIDTH: write data.
- `b_valid` in 1; `b_ready` out 1.
- `fsm_done` in 1: pulse from `controller_fsm` marking the end of tile compute.
- `wr_addr` out IO_DATA_WIDTH: registered copy of the accepted `a_input`.
- `wr_data` out IO_DATA_WIDTH: registered copy of the accepted `b_input`.
- `int_mem_we` out 1: write strobe for kernel/input memory (decoded downstream by bit 15).
- `overlap_cache_we` out 1: write strobe for the overlap cache.
- `data_ready` out 1: high while a tile is loaded and computing.
- `tile_idx` out $clog2(NB_TILES): index of the current tile.
- `layer_done` out 1: one-cycle pulse at the end of the layer.
- `load_error` out 1: sticky phase-mismatch flag; cleared only by `start` or reset.

## Operation
- States: IDLE, LOAD_KERNEL, LOAD_INPUT, LOAD_OVERLAP, COMPUTE, DONE.
- Acceptance: a word is accepted when `a_valid & b_valid & a_ready & b_ready`.
- `a_ready` and `b_ready` are equal and decoded from the registered state: 1 in the LOAD_* states, 0 otherwise. There is no dependency on `valid`.
- IDLE → LOAD_KERNEL on `start`. This also clears `tile_idx`, `load_error` and the word counter.
- LOAD_KERNEL: every accepted word counts.
  - A word with `a_input[15]==1` produces an `int_mem_we` write.
  - A word with `a_input[15]==0` sets `load_error` and is dropped, with no strobe.
  - After the KERNEL_WORDS-th accepted word: → LOAD_INPUT, counter cleared.
- LOAD_INPUT: same rules, except the required bit is `a_input[15]==0` and the count is INPUT_WORDS.
  - Then → LOAD_OVERLAP, or → COMPUTE if OVERLAP_WORDS==0.
- LOAD_OVERLAP: every accepted word produces an `overlap_cache_we` write; there is no bit-15 check. After OVERLAP_WORDS words: → COMPUTE.
- COMPUTE: `data_ready`=1.
  - On `fsm_done`: if `tile_idx==NB_TILES-1` → DONE; otherwise `tile_idx`+1 and → LOAD_INPUT. The kernel is not reloaded.
- DONE: `layer_done`=1 for one cycle, then → IDLE.
- `fsm_done` outside COMPUTE is ignored. `start` outside IDLE is ignored.
- Counter width is $clog2(max(KERNEL_WORDS, INPUT_WORDS, OVERLAP_WORDS)+1). The counter never wraps, because the phase ends on terminal count.

## Timing
- Reset values: state IDLE; `a_ready`, `b_ready`, `int_mem_we`, `overlap_cache_we`, `data_ready`, `layer_done`, `load_error` all 0; `wr_addr`, `wr_data`, `tile_idx` all 0.
- Write latency: a word accepted in cycle N drives `wr_addr`/`wr_data` and its strobe in cycle N+1. A strobe lasts exactly one cycle per word, so back-to-back words give a continuous strobe.
- On the last word of a phase, accepted in cycle N:
  - the state changes at the edge ending N, so ready is 0 in N+1;
  - `data_ready` rises in N+1, together with the final write strobe;
  - the memory captures that write at the end of N+1, before the controller's first read in N+2.
- `fsm_done` sampled in cycle M:
  - `data_ready` is 0 in M+1 and `tile_idx` is updated in M+1;
  - ready is 1 in M+1 when going to LOAD_INPUT.
- `fsm_done` is honoured in the first cycle of COMPUTE.
- An asynchronous reset mid-phase returns everything to its reset value immediately. A strobe in flight is cancelled.

## Structure
- Package `tile_load_pkg`: state enum `tl_state_t` (6 values, 3-bit encoding) and the bit-15 select constant `KERNEL_SEL_BIT`.
- One sub-module, `tl_word_counter`: clear, increment and terminal-count compare against a phase-length input.
- The rest is a single always_ff state/counter process plus a combinational next-state block.

## Test plan
- Reset, then `start` with KERNEL_WORDS=4, INPUT_WORDS=8, OVERLAP_WORDS=2, NB_TILES=2, and a full stream → expect 12 `int_mem_we` + 2 `overlap_cache_we` writes. Then `data_ready`=1; `fsm_done` → tile 1 reloads 10 words; second `fsm_done` → `layer_done` pulses once and state returns to IDLE.
- A kernel-phase word with `a_input`=0x0003 → `load_error`=1, no strobe, but the word is counted. `load_error` stays 1 until the next `start`.
- Valid toggling every other cycle → ready never drops mid-phase; strobe count equals accepted words; `wr_addr`/`wr_data` match the accepted values one cycle later.
- OVERLAP_WORDS=0 → LOAD_INPUT goes straight to COMPUTE; `overlap_cache_we` is never asserted.
- Spurious `fsm_done` during LOAD_INPUT and `start` during COMPUTE → no state change.
- `arst_n_in` low after 3 input words → all outputs read 0 next cycle. A new `start` reloads the kernel from word 0.
